// File: rtl/ram1p_initiator.sv
// Request/response front end for a single-port SRAM with 1-cycle read latency.
// Optionally zeroes the whole array after reset, then serves one read or
// write per cycle and stalls requests while a read response is back-pressured.
module ram1p_initiator #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 44,
    parameter bit CLEAR_ON_RESET = 1'b1,
    localparam int NB = (WIDTH - 1) / 8 + 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    // request channel
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic             ReqWrite,
    input  logic [AW-1:0]    ReqAdr,
    input  logic [WIDTH-1:0] ReqData,
    input  logic [NB-1:0]    ReqByteMask,
    // read-response channel
    output logic             RspValid,
    input  logic             RspReady,
    output logic [WIDTH-1:0] RspData,
    output logic             Busy,
    // SRAM port
    output logic             ce,
    output logic [AW-1:0]    addr,
    output logic [WIDTH-1:0] din,
    output logic             we,
    output logic [NB-1:0]    bwe,
    input  logic [WIDTH-1:0] dout
);

    typedef enum logic [1:0] {
        CLEAR,
        READY,
        RSPWAIT
    } state_t;

    state_t        state;
    logic [AW-1:0] counter;
    logic          accept;

    // The SRAM holds dout until the next ce cycle, so the response data is
    // taken straight from it; every stall path keeps ce low.
    assign RspData = dout;

    // Request handshake: only in READY, and only if the response slot frees up.
    always_comb begin
        ReqReady = ~reset & (state == READY) & (~RspValid | RspReady);
        accept   = ReqValid & ReqReady;
    end

    // SRAM port drive: clear sweep, accepted request, or idle.
    always_comb begin
        ce   = 1'b0;
        we   = 1'b0;
        addr = ReqAdr;
        din  = ReqData;
        bwe  = '1;
        if (!reset && state == CLEAR) begin
            ce   = 1'b1;
            we   = 1'b1;
            addr = counter;
            din  = '0;
            bwe  = '1;
        end else if (accept) begin
            ce  = 1'b1;
            we  = ReqWrite;
            bwe = ReqWrite ? ReqByteMask : '1;
        end
    end

    // Control FSM with registered Busy and RspValid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR_ON_RESET ? CLEAR : READY;
            counter  <= '0;
            RspValid <= 1'b0;
            Busy     <= CLEAR_ON_RESET;
        end else begin
            case (state)
                CLEAR: begin
                    counter <= counter + 1'b1;
                    if (counter == AW'(DEPTH - 1)) begin
                        state   <= READY;
                        Busy    <= 1'b0;
                        counter <= '0;
                    end
                end
                READY: begin
                    if (accept) begin
                        // A consumed response may be replaced in the same cycle.
                        RspValid <= ~ReqWrite;
                    end else if (RspValid && RspReady) begin
                        RspValid <= 1'b0;
                    end else if (RspValid && !RspReady) begin
                        state <= RSPWAIT;
                    end
                end
                RSPWAIT: begin
                    if (RspReady) begin
                        RspValid <= 1'b0;
                        state    <= READY;
                    end
                end
                default: begin
                    state    <= CLEAR_ON_RESET ? CLEAR : READY;
                    counter  <= '0;
                    RspValid <= 1'b0;
                    Busy     <= CLEAR_ON_RESET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram1p_initiator.sv
// Bench for ram1p_initiator: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the memory.
module tb_ram1p_initiator;

    localparam int DEPTH = 64;
    localparam int WIDTH = 44;
    localparam int NB = (WIDTH - 1) / 8 + 1;
    localparam int AW = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             ReqValid = 1'b0;
    logic             ReqReady;
    logic             ReqWrite = 1'b0;
    logic [AW-1:0]    ReqAdr = '0;
    logic [WIDTH-1:0] ReqData = '0;
    logic [NB-1:0]    ReqByteMask = '0;
    logic             RspValid;
    logic             RspReady = 1'b1;
    logic [WIDTH-1:0] RspData;
    logic             Busy;
    logic             ce;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] din;
    logic             we;
    logic [NB-1:0]    bwe;
    logic [WIDTH-1:0] dout;

    int n_cmp = 0;
    int n_bad = 0;

    ram1p_initiator #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ReqValid(ReqValid),
        .ReqReady(ReqReady),
        .ReqWrite(ReqWrite),
        .ReqAdr(ReqAdr),
        .ReqData(ReqData),
        .ReqByteMask(ReqByteMask),
        .RspValid(RspValid),
        .RspReady(RspReady),
        .RspData(RspData),
        .Busy(Busy),
        .ce(ce),
        .addr(addr),
        .din(din),
        .we(we),
        .bwe(bwe),
        .dout(dout)
    );

    always #5 clk = ~clk;

    // Behavioural single-port SRAM: byte-masked write, read returns old contents.
    logic [WIDTH-1:0] sram [DEPTH];
    always @(posedge clk) begin
        if (ce) begin
            if (we) begin
                for (int i = 0; i < WIDTH; i++)
                    if (bwe[i/8]) sram[addr][i] <= din[i];
            end
            dout <= sram[addr];
        end
    end

    // Reference model: memory contents, remaining clear cycles, pending response.
    logic [WIDTH-1:0] ref_mem [DEPTH];
    int               clear_left = DEPTH;
    bit               rsp_pending = 1'b0;
    bit               rsp_stalled = 1'b0;
    logic [WIDTH-1:0] rsp_data = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: check outputs at the falling edge, advance the model at the rising edge.
    task automatic tick();
        bit exp_ready;
        bit acc;
        bit consumed;
        exp_ready = 1'b0;
        acc = 1'b0;
        @(negedge clk);
        if (reset) begin
            check("rst_ready", 64'(ReqReady), 64'd0);
            check("rst_rspvalid", 64'(RspValid), 64'd0);
            check("rst_ce", 64'(ce), 64'd0);
        end else if (clear_left > 0) begin
            check("clr_busy", 64'(Busy), 64'd1);
            check("clr_ready", 64'(ReqReady), 64'd0);
            check("clr_rspvalid", 64'(RspValid), 64'd0);
            check("clr_ce", 64'(ce), 64'd1);
            check("clr_we", 64'(we), 64'd1);
            check("clr_addr", 64'(addr), 64'(DEPTH - clear_left));
            check("clr_din", 64'(din), 64'd0);
            check("clr_bwe", 64'(bwe), 64'({NB{1'b1}}));
        end else begin
            exp_ready = !rsp_pending || (RspReady && !rsp_stalled);
            acc = ReqValid && exp_ready;
            check("busy", 64'(Busy), 64'd0);
            check("ready", 64'(ReqReady), 64'(exp_ready));
            check("rspvalid", 64'(RspValid), 64'(rsp_pending));
            if (rsp_pending) check("rspdata", 64'(RspData), 64'(rsp_data));
            check("ce", 64'(ce), 64'(acc));
            if (!acc) check("we_idle", 64'(we), 64'd0);
            else begin
                check("we", 64'(we), 64'(ReqWrite));
                check("addr", 64'(addr), 64'(ReqAdr));
                check("din", 64'(din), 64'(ReqData));
                check("bwe", 64'(bwe), ReqWrite ? 64'(ReqByteMask) : 64'({NB{1'b1}}));
            end
        end
        @(posedge clk);
        if (reset) begin
            clear_left = DEPTH;
            rsp_pending = 1'b0;
            rsp_stalled = 1'b0;
        end else if (clear_left > 0) begin
            ref_mem[DEPTH - clear_left] = '0;
            clear_left--;
        end else begin
            consumed = rsp_pending && RspReady;
            rsp_stalled = rsp_pending && !RspReady;
            if (consumed) rsp_pending = 1'b0;
            if (acc) begin
                if (ReqWrite) begin
                    for (int i = 0; i < WIDTH; i++)
                        if (ReqByteMask[i/8]) ref_mem[ReqAdr][i] = ReqData[i];
                end else begin
                    rsp_pending = 1'b1;
                    rsp_data = ref_mem[ReqAdr];
                end
            end
        end
        #1;
    endtask

    task automatic req(input bit w, input int a, input logic [WIDTH-1:0] d, input logic [NB-1:0] m);
        ReqValid = 1'b1;
        ReqWrite = w;
        ReqAdr = AW'(a);
        ReqData = d;
        ReqByteMask = m;
    endtask

    task automatic idle();
        ReqValid = 1'b0;
        ReqWrite = 1'b0;
    endtask

    task automatic rand_inputs();
        ReqValid = ($urandom_range(0, 99) < 60);
        ReqWrite = $urandom_range(0, 1) == 1;
        ReqAdr = AW'($urandom_range(0, DEPTH - 1));
        ReqData = WIDTH'({$urandom(), $urandom()});
        ReqByteMask = NB'($urandom());
        RspReady = ($urandom_range(0, 99) < 65);
    endtask

    int n;
    logic [WIDTH-1:0] held;
    logic [WIDTH-1:0] d1, d2, d3;

    initial begin
        // Settle state out of X before any output is compared.
        @(posedge clk);
        #1;
        tick();
        check("rst_busy", 64'(Busy), 64'd1);

        // Clear sweep after reset.
        reset = 1'b0;
        n = 0;
        while (Busy === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("clear_len", 64'(n), 64'(DEPTH));

        // Cleared words read back as zero.
        RspReady = 1'b1;
        foreach (d1[i]) ;
        for (int k = 0; k < 3; k++) begin
            req(1'b0, (k == 0) ? 0 : (k == 1) ? 17 : 63, '0, '0);
            tick();
            check("rd_clr_valid", 64'(RspValid), 64'd1);
            check("rd_clr_data", 64'(RspData), 64'd0);
        end
        idle();
        tick();

        // Single-lane write merges into a zero word.
        req(1'b1, 5, '1, NB'(6'b000010));
        tick();
        req(1'b0, 5, '0, '0);
        tick();
        check("lane1_valid", 64'(RspValid), 64'd1);
        check("lane1_data", 64'(RspData), 64'h0000_0000_FF00);
        idle();
        tick();

        // Full-word write, read on the very next cycle.
        req(1'b1, 5, 44'h0AB_CDEF_1234, '1);
        tick();
        req(1'b0, 5, '0, '0);
        tick();
        check("full_valid", 64'(RspValid), 64'd1);
        check("full_data", 64'(RspData), 64'h0AB_CDEF_1234);
        idle();
        tick();

        // Back-pressured read: response held, requests blocked.
        req(1'b1, 9, 44'h123_4567_89AB, '1);
        tick();
        RspReady = 1'b0;
        req(1'b0, 9, '0, '0);
        tick();
        held = RspData;
        check("bp_first", 64'(held), 64'h123_4567_89AB);
        req(1'b1, 9, '0, '1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("bp_valid", 64'(RspValid), 64'd1);
            check("bp_data", 64'(RspData), 64'(held));
        end
        idle();
        RspReady = 1'b1;
        tick();
        check("bp_drop", 64'(RspValid), 64'd0);
        check("bp_ready", 64'(ReqReady), 64'd1);

        // Back-to-back reads at full rate.
        d1 = 44'h111_0000_0001;
        d2 = 44'h222_0000_0002;
        d3 = 44'h333_0000_0003;
        req(1'b1, 1, d1, '1);
        tick();
        req(1'b1, 2, d2, '1);
        tick();
        req(1'b1, 3, d3, '1);
        tick();
        req(1'b0, 1, '0, '0);
        tick();
        check("b2b_v1", 64'(RspValid), 64'd1);
        check("b2b_d1", 64'(RspData), 64'(d1));
        req(1'b0, 2, '0, '0);
        tick();
        check("b2b_v2", 64'(RspValid), 64'd1);
        check("b2b_d2", 64'(RspData), 64'(d2));
        req(1'b0, 3, '0, '0);
        tick();
        check("b2b_v3", 64'(RspValid), 64'd1);
        check("b2b_d3", 64'(RspData), 64'(d3));
        idle();
        tick();
        check("b2b_end", 64'(RspValid), 64'd0);

        // Reset 30 cycles into a clear restarts the full sweep.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 30; k++) begin
            rand_inputs();
            tick();
        end
        reset = 1'b1;
        tick();
        check("rst2_busy", 64'(Busy), 64'd1);
        reset = 1'b0;
        n = 0;
        while (Busy === 1'b1 && n < 200) begin
            rand_inputs();
            tick();
            n++;
        end
        check("clear2_len", 64'(n), 64'(DEPTH));

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            rand_inputs();
            reset = ($urandom_range(0, 999) == 0);
            tick();
        end
        reset = 1'b0;
        idle();
        RspReady = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
